param_sram: RTL and testbench
=============================

PARAM_SRAM -- requirements
Module: param_sram

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 6: address width; depth SHALL be DEPTH = 2**ADDR_W words.
REQ-003 Parameter CLR_VAL, default 0: DATA_W-bit value written to every word by the clear sweep.
REQ-004 Derived localparam BE_W = DATA_W/8: number of byte lanes.
REQ-005 Port i_clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-006 Port i_rst_n  input  1: reset, asynchronous, active-low.
REQ-007 Port i_ce  input  1: access enable.
REQ-008 Port i_rw  input  1: 0 = write, 1 = read.
REQ-009 Port i_be  input  BE_W: byte-lane write enables; bit k covers data bits [8k+7:8k].
REQ-010 Port i_addr  input  ADDR_W: word address.
REQ-011 Port i_data  input  DATA_W: write data.
REQ-012 Port o_data  output  DATA_W: registered read data.
REQ-013 Port o_valid  output  1: one-cycle pulse marking o_data as a new read result.
REQ-014 Port o_busy  output  1: high while the clear sweep runs; accesses are ignored.

Function
REQ-015 Controller SHALL have two states, CLEAR and READY; reset forces CLEAR with sweep address 0.
REQ-016 In CLEAR, each cycle SHALL write CLR_VAL to all lanes of mem[sweep address], then increment the sweep address.
REQ-017 After writing address DEPTH-1, state SHALL move to READY; sweep SHALL take exactly DEPTH cycles from the first clock edge after reset release.
REQ-018 o_busy SHALL be 1 in CLEAR and 0 in READY, driven from registered state.
REQ-019 In CLEAR, i_ce/i_rw/i_be/i_data SHALL be ignored: no user write, o_valid stays 0, o_data holds.
REQ-020 READY write (i_ce=1, i_rw=0): only lanes with i_be[k]=1 SHALL update at the clock edge; other lanes keep their value; o_data holds; o_valid=0.
REQ-021 READY write with i_be all zero SHALL leave memory unchanged.
REQ-022 READY read (i_ce=1, i_rw=1): o_data SHALL equal mem[i_addr] one cycle later, with o_valid=1 in that cycle; i_be ignored.
REQ-023 Back-to-back reads SHALL be accepted every cycle, one o_valid pulse per accepted read, in order.
REQ-024 i_ce=0: no access; o_valid=0 next cycle; o_data holds its last value.
REQ-025 A read following a write to the same address on the next cycle SHALL return the newly written data.
REQ-026 Addresses SHALL wrap naturally within ADDR_W bits; no out-of-range access exists.

Reset
REQ-027 Reset assertion SHALL immediately set o_data=0, o_valid=0, o_busy=1, state=CLEAR, sweep address=0.
REQ-028 Reset mid-sweep or mid-read SHALL discard in-flight results and restart the sweep from address 0.
REQ-029 Memory array contents SHALL NOT be reset directly; the sweep establishes CLR_VAL.

Configuration
REQ-030 Macro SRAM_OUT_REG_EN defined: one extra output register stage SHALL be inserted; read latency 2 cycles; o_valid delayed identically; throughput stays one read per cycle; extra stage resets to 0.
REQ-031 Macro SRAM_OUT_REG_EN undefined: read latency SHALL be 1 cycle as in REQ-022.

Verification (DATA_W=16, ADDR_W=6, CLR_VAL=16'hA5A5, macro undefined unless noted)
REQ-032 Release reset -> o_busy=1 for exactly 64 cycles, then 0; reading addresses 0, 31, 63 returns 16'hA5A5 with o_valid pulses.
REQ-033 Write addr 5, data 16'h1234, i_be=2'b01; then read addr 5 -> o_data=16'hA534 one cycle later, o_valid=1 for one cycle.
REQ-034 Reads of addrs 1,2,3 on consecutive cycles after writing 16'h0001/0002/0003 -> o_data 0001,0002,0003 on three consecutive cycles, o_valid high for 3 cycles.
REQ-035 Write addr 10 = 16'hBEEF during o_busy=1, then read addr 10 after sweep -> 16'hA5A5.
REQ-036 Assert i_rst_n low at sweep address 20, release -> o_busy high a further 64 cycles; o_data=0, o_valid=0 during reset.
REQ-037 With SRAM_OUT_REG_EN: write addr 7 = 16'hCAFE, read addr 7 -> o_data=16'hCAFE and o_valid=1 exactly two cycles after the read cycle.

Source files
------------

// File: rtl/param_sram.sv
`default_nettype none
// ============================================================================
// Module      : param_sram
// Description : Single-port SRAM with byte-lane write enables, registered read
//               data and a self-clearing sweep that fills every word with
//               CLR_VAL after reset. Optional macro SRAM_OUT_REG_EN adds one
//               output register stage (read latency 2 instead of 1).
// Revision    : 1.0 - initial release
// ============================================================================
module param_sram #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 6,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ce,
  input  logic                 i_rw,
  input  logic [DATA_W/8-1:0]  i_be,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]    i_data,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_valid,
  output logic                 o_busy
);

  localparam int                BE_W        = DATA_W / 8;
  localparam int                DEPTH       = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   sweep_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   rdata_d;
  logic                rvalid_q;
  logic                wr_en;
  logic                rd_en;

  // User accesses are only honoured once the clear sweep has finished
  assign wr_en = (state_q == READY) && i_ce && !i_rw;
  assign rd_en = (state_q == READY) && i_ce &&  i_rw;

  // Controller: walk every address once in CLEAR, then settle in READY
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CLEAR;
      sweep_q <= '0;
    end else if (state_q == CLEAR) begin
      sweep_q <= sweep_q + ADDR_W'(1);
      if (sweep_q == c_LAST_ADDR) begin
        state_q <= READY;
      end
    end
  end

  // Storage array: sweep writes whole words, user writes are per byte lane.
  // The array itself carries no reset; the sweep establishes its contents.
  always_ff @(posedge i_clk) begin
    if (state_q == CLEAR) begin
      mem_q[sweep_q] <= CLR_VAL;
    end else if (wr_en) begin
      for (int k = 0; k < BE_W; k++) begin
        if (i_be[k]) begin
          mem_q[i_addr][8*k +: 8] <= i_data[8*k +: 8];
        end
      end
    end
  end

  // Next read data: new word on an accepted read, otherwise hold
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem_q[i_addr];
    end
  end

  // First read stage: registered data plus one-cycle valid pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rd_en;
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic [DATA_W-1:0] dly_data_q;
  logic              dly_valid_q;

  // Extra output stage: delays data and valid together, still one read/cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dly_data_q  <= '0;
      dly_valid_q <= 1'b0;
    end else begin
      dly_data_q  <= rdata_q;
      dly_valid_q <= rvalid_q;
    end
  end

  assign o_data  = dly_data_q;
  assign o_valid = dly_valid_q;
`else
  assign o_data  = rdata_q;
  assign o_valid = rvalid_q;
`endif

  assign o_busy = (state_q == CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_param_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_sram
// Description : Directed self-checking bench for param_sram
//               (DATA_W=16, ADDR_W=6, CLR_VAL=16'hA5A5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_sram;

`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        rw;
  logic [1:0]  be;
  logic [5:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        valid;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  param_sram #(
    .DATA_W (16),
    .ADDR_W (6),
    .CLR_VAL(16'hA5A5)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_ce   (ce),
    .i_rw   (rw),
    .i_be   (be),
    .i_addr (addr),
    .i_data (wdata),
    .o_data (rdata),
    .o_valid(valid),
    .o_busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] b);
    ce = 1'b1; rw = 1'b0; addr = a; wdata = d; be = b;
    tick();
    ce = 1'b0;
  endtask

  // Single read; i_be/i_data are set to junk to show they are ignored
  task automatic rd(input logic [5:0] a, input logic [15:0] exp, input string tag);
    ce = 1'b1; rw = 1'b1; addr = a; be = 2'b11; wdata = 16'hDEAD;
    for (int c = 1; c <= LAT + 1; c++) begin
      tick();
      ce = 1'b0;
      check({tag, " valid"}, valid, (c == LAT));
      if (c == LAT) check({tag, " data"}, rdata, exp);
    end
  endtask

  // Run out the clear sweep while poking writes/reads that must be ignored
  task automatic run_sweep(output int cycles, output bit saw_valid);
    cycles = 0;
    saw_valid = 1'b0;
    do begin
      if (cycles == 30) begin ce = 1'b1; rw = 1'b0; addr = 6'd10; wdata = 16'hBEEF; be = 2'b11; end
      if (cycles == 40) begin rw = 1'b1; addr = 6'd0; end
      if (cycles == 50) ce = 1'b0;
      tick();
      cycles++;
      if (valid) saw_valid = 1'b1;
    end while (busy && cycles < 200);
    ce = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    bit sv;
    int j;

    rst_n = 1'b1; ce = 1'b0; rw = 1'b0; be = '0; addr = '0; wdata = '0;
    #2 rst_n = 1'b0;
    #2;
    check("rst data",  rdata, 16'h0000);
    check("rst valid", valid, 1'b0);
    check("rst busy",  busy,  1'b1);
    tick(); tick();
    rst_n = 1'b1;

    // Sweep length, ignored accesses during sweep
    run_sweep(cyc, sv);
    check("sweep cycles", cyc, 64);
    check("sweep no valid", sv, 1'b0);
    check("sweep data held", rdata, 16'h0000);
    check("ready busy", busy, 1'b0);

    rd(6'd0,  16'hA5A5, "clr a0");
    rd(6'd31, 16'hA5A5, "clr a31");
    rd(6'd63, 16'hA5A5, "clr a63");
    rd(6'd10, 16'hA5A5, "busy wr ignored");

    // Partial lane write then immediate read
    wr(6'd5, 16'h1234, 2'b01);
    rd(6'd5, 16'hA534, "lane0 wr");
    wr(6'd5, 16'h77FF, 2'b10);
    rd(6'd5, 16'h7734, "lane1 wr");
    wr(6'd20, 16'hFFFF, 2'b00);
    rd(6'd20, 16'hA5A5, "be zero");
    wr(6'd63, 16'h0F0F, 2'b11);
    rd(6'd63, 16'h0F0F, "top addr");

    // Back-to-back reads
    wr(6'd1, 16'h0001, 2'b11);
    wr(6'd2, 16'h0002, 2'b11);
    wr(6'd3, 16'h0003, 2'b11);
    ce = 1'b1; rw = 1'b1; addr = 6'd1;
    for (int c = 1; c <= 3 + LAT; c++) begin
      tick();
      if (c < 3) addr = 6'(c + 1);
      else ce = 1'b0;
      j = c - LAT;
      check("b2b valid", valid, (j >= 0 && j <= 2));
      if (j >= 0 && j <= 2) check("b2b data", rdata, 16'(j + 1));
    end

    // ce=0: nothing happens, output holds
    wr(6'd7, 16'hCAFE, 2'b11);
    rd(6'd7, 16'hCAFE, "cafe");
    ce = 1'b0; rw = 1'b0; addr = 6'd7; wdata = 16'h0000; be = 2'b11;
    tick(); tick();
    check("idle valid", valid, 1'b0);
    check("idle hold", rdata, 16'hCAFE);
    rd(6'd7, 16'hCAFE, "idle no wr");

    // Reset while a read result is in flight
    ce = 1'b1; rw = 1'b1; addr = 6'd5;
    tick();
    ce = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst mid data",  rdata, 16'h0000);
    check("rst mid valid", valid, 1'b0);
    check("rst mid busy",  busy,  1'b1);
    tick();
    rst_n = 1'b1;

    // Abort the sweep at address 20, then restart
    repeat (20) tick();
    check("part sweep busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst20 data",  rdata, 16'h0000);
    check("rst20 valid", valid, 1'b0);
    tick();
    check("rst20 busy", busy, 1'b1);
    rst_n = 1'b1;
    run_sweep(cyc, sv);
    check("resweep cycles", cyc, 64);
    check("resweep no valid", sv, 1'b0);
    rd(6'd5,  16'hA5A5, "resweep a5");
    rd(6'd7,  16'hA5A5, "resweep a7");
    rd(6'd63, 16'hA5A5, "resweep a63");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
